ctrl_fsm: RTL and testbench

Multi-cycle control sequencer for the cotm32 RV32I core. It walks each instruction through fetch, decode, execute, memory and writeback. It decodes the opcode of the latched instruction into the immediate-format select for `sign_ext`, and it generates the IR, PC, register-file and data-memory strobes. It sits between the instruction register and the datapath. It is the only driver of `sign_ext.i_sel`.

---
 rtl/cotm32_pkg.sv | 51 +++++
 rtl/inst_class_dec.sv | 31 +++
 rtl/ctrl_fsm.sv | 128 ++++++++++++
 tb/tb_ctrl_fsm.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/cotm32_pkg.sv
// rtl/cotm32_pkg.sv - shared cotm32 types, opcodes and control-sequencer enums
package cotm32_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_t;

    typedef enum logic {
        PC_PLUS4  = 1'b0,
        PC_TARGET = 1'b1
    } pc_sel_t;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } ctrl_state_t;

    // Classes group opcodes that share one path through the sequencer.
    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_JUMP    = 3'd1,
        CLS_BRANCH  = 3'd2,
        CLS_LOAD    = 3'd3,
        CLS_STORE   = 3'd4,
        CLS_SYS     = 3'd5,
        CLS_ILLEGAL = 3'd6
    } inst_class_t;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

endpackage

// File: rtl/inst_class_dec.sv
// rtl/inst_class_dec.sv - opcode to instruction class, immediate format and legal flag
module inst_class_dec
    import cotm32_pkg::*;
(
    input  logic [6:0]  i_opcode,
    output inst_class_t o_class,
    output imm_t        o_imm,
    output logic        o_legal
);

    always_comb begin
        o_class = CLS_ILLEGAL;
        o_imm   = IMM_I;
        o_legal = 1'b1;
        case (i_opcode)
            OPC_LUI:      begin o_class = CLS_ALU;    o_imm = IMM_U; end
            OPC_AUIPC:    begin o_class = CLS_ALU;    o_imm = IMM_U; end
            OPC_JAL:      begin o_class = CLS_JUMP;   o_imm = IMM_J; end
            OPC_JALR:     begin o_class = CLS_JUMP;   o_imm = IMM_I; end
            OPC_BRANCH:   begin o_class = CLS_BRANCH; o_imm = IMM_B; end
            OPC_LOAD:     begin o_class = CLS_LOAD;   o_imm = IMM_I; end
            OPC_STORE:    begin o_class = CLS_STORE;  o_imm = IMM_S; end
            OPC_OP_IMM:   begin o_class = CLS_ALU;    o_imm = IMM_I; end
            OPC_OP:       begin o_class = CLS_ALU;    o_imm = IMM_I; end
            OPC_MISC_MEM: begin o_class = CLS_SYS;    o_imm = IMM_I; end
            OPC_SYSTEM:   begin o_class = CLS_SYS;    o_imm = IMM_I; end
            default:      o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/ctrl_fsm.sv
// rtl/ctrl_fsm.sv - cotm32 multi-cycle control sequencer; COTM32_ILLEGAL_TRAP_EN adds the TRAP state and o_trap
module ctrl_fsm
    import cotm32_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_inst,
    input  logic            i_mem_ready,
    input  logic            i_br_taken,
    output imm_t            o_imm_sel,
    output logic            o_ir_we,
    output logic            o_pc_we,
    output pc_sel_t         o_pc_sel,
    output logic            o_mem_req,
    output logic            o_mem_we,
    output logic            o_mem_addr_pc,
`ifdef COTM32_ILLEGAL_TRAP_EN
    output logic            o_trap,
`endif
    output logic            o_rf_we
);

    ctrl_state_t r_state;
    ctrl_state_t w_next;
    inst_class_t w_class;
    imm_t        w_imm;
    logic        w_legal;

    inst_class_dec u_dec (
        .i_opcode (i_inst[6:0]),
        .o_class  (w_class),
        .o_imm    (w_imm),
        .o_legal  (w_legal)
    );

`ifdef COTM32_ILLEGAL_TRAP_EN
    logic w_unused_inst;
    assign w_unused_inst = ^i_inst[XLEN-1:7];
`else
    logic w_unused_inst;
    assign w_unused_inst = ^{i_inst[XLEN-1:7], w_legal};
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH:  if (i_mem_ready) w_next = ST_DECODE;
            ST_DECODE: begin
                w_next = ST_EXEC;
`ifdef COTM32_ILLEGAL_TRAP_EN
                if (!w_legal) w_next = ST_TRAP;
`endif
            end
            ST_EXEC: begin
                case (w_class)
                    CLS_LOAD, CLS_STORE:             w_next = ST_MEM;
                    CLS_BRANCH, CLS_SYS, CLS_ILLEGAL: w_next = ST_FETCH;
                    default:                         w_next = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (i_mem_ready) w_next = (w_class == CLS_STORE) ? ST_FETCH : ST_WB;
            end
            ST_WB:   w_next = ST_FETCH;
`ifdef COTM32_ILLEGAL_TRAP_EN
            ST_TRAP: w_next = ST_TRAP;
`endif
            default: w_next = ST_FETCH;
        endcase
    end

    // Outputs are forced to their idle values while reset is held, whatever the state.
    always_comb begin
        o_imm_sel     = (i_rst || r_state == ST_FETCH) ? IMM_I : w_imm;
        o_ir_we       = 1'b0;
        o_pc_we       = 1'b0;
        o_pc_sel      = PC_PLUS4;
        o_mem_req     = 1'b0;
        o_mem_we      = 1'b0;
        o_mem_addr_pc = 1'b0;
        o_rf_we       = 1'b0;
`ifdef COTM32_ILLEGAL_TRAP_EN
        o_trap        = 1'b0;
`endif
        if (!i_rst) begin
            case (r_state)
                ST_FETCH: begin
                    o_mem_req     = 1'b1;
                    o_mem_addr_pc = 1'b1;
                    o_ir_we       = i_mem_ready;
                end
                ST_EXEC: begin
                    case (w_class)
                        CLS_BRANCH: begin
                            o_pc_we  = 1'b1;
                            o_pc_sel = i_br_taken ? PC_TARGET : PC_PLUS4;
                        end
                        CLS_SYS, CLS_ILLEGAL: o_pc_we = 1'b1;
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    o_mem_req = 1'b1;
                    o_mem_we  = (w_class == CLS_STORE);
                    o_pc_we   = i_mem_ready && (w_class == CLS_STORE);
                end
                ST_WB: begin
                    o_rf_we  = 1'b1;
                    o_pc_we  = 1'b1;
                    o_pc_sel = (w_class == CLS_JUMP) ? PC_TARGET : PC_PLUS4;
                end
`ifdef COTM32_ILLEGAL_TRAP_EN
                ST_TRAP: o_trap = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb/tb_ctrl_fsm.sv - table-driven self-checking bench for ctrl_fsm
module tb_ctrl_fsm;
    import cotm32_pkg::*;

    localparam logic [31:0] ADDI  = 32'h09000913;
    localparam logic [31:0] SW    = 32'hff312e23;
    localparam logic [31:0] BEQ   = 32'hff390ce3;
    localparam logic [31:0] LUI   = 32'h00abca37;
    localparam logic [31:0] JAL   = 32'hffdff06f;
    localparam logic [31:0] LW    = 32'h00052283;
    localparam logic [31:0] ECALL = 32'h00000073;
    localparam logic [31:0] ILL   = 32'h0000007f;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst = ADDI;
    logic        rdy = 1'b0;
    logic        br = 1'b0;
    imm_t        o_imm_sel;
    logic        o_ir_we, o_pc_we, o_mem_req, o_mem_we, o_mem_addr_pc, o_rf_we;
    pc_sel_t     o_pc_sel;
    logic        w_trap;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ctrl_fsm dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_inst        (inst),
        .i_mem_ready   (rdy),
        .i_br_taken    (br),
        .o_imm_sel     (o_imm_sel),
        .o_ir_we       (o_ir_we),
        .o_pc_we       (o_pc_we),
        .o_pc_sel      (o_pc_sel),
        .o_mem_req     (o_mem_req),
        .o_mem_we      (o_mem_we),
        .o_mem_addr_pc (o_mem_addr_pc),
`ifdef COTM32_ILLEGAL_TRAP_EN
        .o_trap        (w_trap),
`endif
        .o_rf_we       (o_rf_we)
    );

`ifndef COTM32_ILLEGAL_TRAP_EN
    assign w_trap = 1'b0;
`endif

    // Expected field order: {imm[2:0], ir_we, pc_we, pc_sel, mem_req, mem_we, addr_pc, rf_we, trap}
    typedef struct {
        logic        rst;
        logic [31:0] inst;
        logic        rdy;
        logic        br;
        logic [10:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic r, input logic [31:0] ins, input logic rd,
                       input logic b, input imm_t imm, input logic ir, input logic pw,
                       input logic ps, input logic rq, input logic we, input logic apc,
                       input logic rf, input logic tr);
        vec_t v;
        v.rst  = r;
        v.inst = ins;
        v.rdy  = rd;
        v.br   = b;
        v.exp  = {imm, ir, pw, ps, rq, we, apc, rf, tr};
        v.name = name;
        vecs.push_back(v);
    endtask

    // One cycle: drive on the falling edge, sample before the next rising edge.
    task automatic step(input vec_t v);
        logic [10:0] act;
        @(negedge clk);
        rst  = v.rst;
        inst = v.inst;
        rdy  = v.rdy;
        br   = v.br;
        #2;
        act = {o_imm_sel, o_ir_we, o_pc_we, o_pc_sel, o_mem_req, o_mem_we,
               o_mem_addr_pc, o_rf_we, w_trap};
        n_checks++;
        if (act !== v.exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (imm,ir,pcwe,pcsel,req,we,apc,rf,trap)",
                     v.name, act, v.exp);
        end
    endtask

    initial begin
        //   name       rst inst  rdy br imm    ir pw ps rq we ap rf tr
        add("rst0",     1, ADDI,  1, 0, IMM_I, 0, 0, 0, 0, 0, 0, 0, 0);
        add("rst1",     1, SW,    1, 1, IMM_I, 0, 0, 0, 0, 0, 0, 0, 0);
        add("addi_f",   0, ADDI,  1, 0, IMM_I, 1, 0, 0, 1, 0, 1, 0, 0);
        add("addi_d",   0, ADDI,  1, 0, IMM_I, 0, 0, 0, 0, 0, 0, 0, 0);
        add("addi_e",   0, ADDI,  1, 0, IMM_I, 0, 0, 0, 0, 0, 0, 0, 0);
        add("addi_wb",  0, ADDI,  1, 0, IMM_I, 0, 1, 0, 0, 0, 0, 1, 0);
        add("sw_f",     0, SW,    1, 0, IMM_I, 1, 0, 0, 1, 0, 1, 0, 0);
        add("sw_d",     0, SW,    0, 0, IMM_S, 0, 0, 0, 0, 0, 0, 0, 0);
        add("sw_e",     0, SW,    1, 0, IMM_S, 0, 0, 0, 0, 0, 0, 0, 0);
        add("sw_m0",    0, SW,    0, 0, IMM_S, 0, 0, 0, 1, 1, 0, 0, 0);
        add("sw_m1",    0, SW,    0, 0, IMM_S, 0, 0, 0, 1, 1, 0, 0, 0);
        add("sw_m2",    0, SW,    1, 0, IMM_S, 0, 1, 0, 1, 1, 0, 0, 0);
        add("beq_fw",   0, BEQ,   0, 1, IMM_I, 0, 0, 0, 1, 0, 1, 0, 0);
        add("beq_f",    0, BEQ,   1, 1, IMM_I, 1, 0, 0, 1, 0, 1, 0, 0);
        add("beq_d",    0, BEQ,   1, 1, IMM_B, 0, 0, 0, 0, 0, 0, 0, 0);
        add("beq_e_t",  0, BEQ,   0, 1, IMM_B, 0, 1, 1, 0, 0, 0, 0, 0);
        add("beq2_f",   0, BEQ,   1, 0, IMM_I, 1, 0, 0, 1, 0, 1, 0, 0);
        add("beq2_d",   0, BEQ,   1, 0, IMM_B, 0, 0, 0, 0, 0, 0, 0, 0);
        add("beq2_e_n", 0, BEQ,   1, 0, IMM_B, 0, 1, 0, 0, 0, 0, 0, 0);
        add("lui_f",    0, LUI,   1, 0, IMM_I, 1, 0, 0, 1, 0, 1, 0, 0);
        add("lui_d",    0, LUI,   1, 0, IMM_U, 0, 0, 0, 0, 0, 0, 0, 0);
        add("lui_e",    0, LUI,   1, 0, IMM_U, 0, 0, 0, 0, 0, 0, 0, 0);
        add("lui_wb",   0, LUI,   1, 0, IMM_U, 0, 1, 0, 0, 0, 0, 1, 0);
        add("jal_f",    0, JAL,   1, 0, IMM_I, 1, 0, 0, 1, 0, 1, 0, 0);
        add("jal_d",    0, JAL,   1, 0, IMM_J, 0, 0, 0, 0, 0, 0, 0, 0);
        add("jal_e",    0, JAL,   1, 0, IMM_J, 0, 0, 0, 0, 0, 0, 0, 0);
        add("jal_wb",   0, JAL,   1, 0, IMM_J, 0, 1, 1, 0, 0, 0, 1, 0);
        add("lw_f",     0, LW,    1, 0, IMM_I, 1, 0, 0, 1, 0, 1, 0, 0);
        add("lw_d",     0, LW,    1, 0, IMM_I, 0, 0, 0, 0, 0, 0, 0, 0);
        add("lw_e",     0, LW,    1, 0, IMM_I, 0, 0, 0, 0, 0, 0, 0, 0);
        add("lw_m",     0, LW,    1, 0, IMM_I, 0, 0, 0, 1, 0, 0, 0, 0);
        add("lw_wb",    0, LW,    1, 0, IMM_I, 0, 1, 0, 0, 0, 0, 1, 0);
        add("ecall_f",  0, ECALL, 1, 0, IMM_I, 1, 0, 0, 1, 0, 1, 0, 0);
        add("ecall_d",  0, ECALL, 1, 0, IMM_I, 0, 0, 0, 0, 0, 0, 0, 0);
        add("ecall_e",  0, ECALL, 1, 0, IMM_I, 0, 1, 0, 0, 0, 0, 0, 0);
        add("ill_f",    0, ILL,   1, 0, IMM_I, 1, 0, 0, 1, 0, 1, 0, 0);
        add("ill_d",    0, ILL,   1, 0, IMM_I, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef COTM32_ILLEGAL_TRAP_EN
        add("trap0",    0, ILL,   1, 0, IMM_I, 0, 0, 0, 0, 0, 0, 0, 1);
        add("trap1",    0, ADDI,  1, 1, IMM_I, 0, 0, 0, 0, 0, 0, 0, 1);
        add("trap2",    0, SW,    0, 0, IMM_S, 0, 0, 0, 0, 0, 0, 0, 1);
        add("trap_rst", 1, ADDI,  1, 0, IMM_I, 0, 0, 0, 0, 0, 0, 0, 0);
        add("post_f",   0, ADDI,  0, 0, IMM_I, 0, 0, 0, 1, 0, 1, 0, 0);
        add("post_f1",  0, ADDI,  1, 0, IMM_I, 1, 0, 0, 1, 0, 1, 0, 0);
        add("post_d",   0, ADDI,  1, 0, IMM_I, 0, 0, 0, 0, 0, 0, 0, 0);
        add("post_e",   0, ADDI,  1, 0, IMM_I, 0, 0, 0, 0, 0, 0, 0, 0);
        add("post_wb",  0, ADDI,  1, 0, IMM_I, 0, 1, 0, 0, 0, 0, 1, 0);
`else
        add("ill_nop",  0, ILL,   1, 0, IMM_I, 0, 1, 0, 0, 0, 0, 0, 0);
        add("post_f",   0, ADDI,  0, 0, IMM_I, 0, 0, 0, 1, 0, 1, 0, 0);
        add("post_f1",  0, ADDI,  1, 0, IMM_I, 1, 0, 0, 1, 0, 1, 0, 0);
        add("post_d",   0, ADDI,  1, 0, IMM_I, 0, 0, 0, 0, 0, 0, 0, 0);
        add("post_e",   0, ADDI,  1, 0, IMM_I, 0, 0, 0, 0, 0, 0, 0, 0);
        add("post_wb",  0, ADDI,  1, 0, IMM_I, 0, 1, 0, 0, 0, 0, 1, 0);
`endif
        foreach (vecs[i]) step(vecs[i]);

        // Reset asserted while a load is waiting in MEM: request dropped, no writeback.
        vecs.delete();
        add("mr_f",     0, LW,    1, 0, IMM_I, 1, 0, 0, 1, 0, 1, 0, 0);
        add("mr_d",     0, LW,    0, 0, IMM_I, 0, 0, 0, 0, 0, 0, 0, 0);
        add("mr_e",     0, LW,    0, 0, IMM_I, 0, 0, 0, 0, 0, 0, 0, 0);
        add("mr_m",     0, LW,    0, 0, IMM_I, 0, 0, 0, 1, 0, 0, 0, 0);
        add("mr_rst",   1, LW,    1, 0, IMM_I, 0, 0, 0, 0, 0, 0, 0, 0);
        add("mr_refw",  0, LW,    0, 0, IMM_I, 0, 0, 0, 1, 0, 1, 0, 0);
        add("mr_ref",   0, LW,    1, 0, IMM_I, 1, 0, 0, 1, 0, 1, 0, 0);
        add("mr_d2",    0, LW,    1, 0, IMM_I, 0, 0, 0, 0, 0, 0, 0, 0);
        foreach (vecs[i]) step(vecs[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
